collision_ctrl: RTL and testbench

- Sits directly downstream of the enemy car stage. Consumes the enemy position (pos_x, pos_y) and the player car position.
- Detects bounding-box overlap and drives the `collision` freeze input back into the enemy stage.
- Runs the hit/freeze/respawn/game-over sequence, counts lives, and counts the score (one point per enemy that leaves the screen).
- All logic runs on the slow game tick logic_clk. The pixel clock domain is untouched.

---
 rtl/collision_ctrl.sv | 126 ++++++++++++
 tb/tb_collision_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/collision_ctrl.sv
// Player/enemy collision, freeze/respawn/game-over sequencing, lives and score on the game tick.
// Optional INVULN_EN adds a post-respawn grace window during which overlap is ignored.
module collision_ctrl #(
  parameter int CAR_W        = 80,
  parameter int CAR_H        = 121,
  parameter int SCREEN_H     = 480,
  parameter int LIVES        = 3,
  parameter int FREEZE_TICKS = 120
`ifdef INVULN_EN
  , parameter int GRACE_TICKS = 60
`endif
) (
  input  logic        logic_clk,
  input  logic        reset,
  input  logic [9:0]  player_x,
  input  logic [9:0]  player_y,
  input  logic [9:0]  enemy_x,
  input  logic [9:0]  enemy_y,
  output logic        collision,
  output logic        respawn,
  output logic [3:0]  lives,
  output logic [15:0] score,
  output logic        game_over,
  output logic        invuln
);

  localparam int CW = (FREEZE_TICKS < 1) ? 1 : $clog2(FREEZE_TICKS + 1);

  typedef enum logic [1:0] {PLAY, HIT, RESPAWN, OVER} state_t;

  state_t          state;
  logic            pass_seen;
  logic [CW-1:0]   tick_cnt;
  logic            ovl;
  logic            passed;
  logic            grace_block;

  // 11-bit sums so a car near the right/bottom edge cannot wrap into a false overlap
  assign ovl = ({1'b0, enemy_x} < ({1'b0, player_x} + 11'(CAR_W))) &&
               ({1'b0, player_x} < ({1'b0, enemy_x} + 11'(CAR_W))) &&
               ({1'b0, enemy_y} < ({1'b0, player_y} + 11'(CAR_H))) &&
               ({1'b0, player_y} < ({1'b0, enemy_y} + 11'(CAR_H)));

  assign passed = ({1'b0, enemy_y} >= 11'(SCREEN_H));

`ifdef INVULN_EN
  localparam int GW = (GRACE_TICKS < 1) ? 1 : $clog2(GRACE_TICKS + 1);
  logic [GW-1:0] grace_cnt;

  assign grace_block = (grace_cnt != '0);

  always_ff @(posedge logic_clk) begin
    if (reset) begin
      grace_cnt <= '0;
      invuln    <= 1'b0;
    end else if (state == RESPAWN) begin
      grace_cnt <= GW'(GRACE_TICKS);
      invuln    <= (GRACE_TICKS != 0);
    end else if (grace_cnt != '0) begin
      grace_cnt <= grace_cnt - GW'(1);
      invuln    <= (grace_cnt != GW'(1));
    end
  end
`else
  assign grace_block = 1'b0;

  always_ff @(posedge logic_clk) begin
    invuln <= 1'b0;
  end
`endif

  // tick_cnt is loaded with FREEZE_TICKS so HIT spans FREEZE_TICKS+1 ticks before the respawn pulse
  always_ff @(posedge logic_clk) begin
    if (reset) begin
      state     <= PLAY;
      collision <= 1'b0;
      respawn   <= 1'b0;
      lives     <= 4'(LIVES);
      score     <= 16'd0;
      game_over <= 1'b0;
      pass_seen <= 1'b0;
      tick_cnt  <= '0;
    end else begin
      respawn <= 1'b0;
      if (!passed) pass_seen <= 1'b0;
      case (state)
        PLAY: begin
          if (ovl && !grace_block) begin
            state     <= HIT;
            collision <= 1'b1;
            lives     <= lives - 4'd1;
            tick_cnt  <= CW'(FREEZE_TICKS);
          end else if (passed && !pass_seen) begin
            score     <= score + 16'd1;
            pass_seen <= 1'b1;
            respawn   <= 1'b1;
          end
        end
        HIT: begin
          if (lives == 4'd0) begin
            state     <= OVER;
            game_over <= 1'b1;
          end else if (tick_cnt == '0) begin
            state     <= RESPAWN;
            collision <= 1'b0;
            respawn   <= 1'b1;
          end else begin
            tick_cnt <= tick_cnt - CW'(1);
          end
        end
        RESPAWN: begin
          // the freshly respawned enemy must not be scored as a pass
          state     <= PLAY;
          pass_seen <= 1'b1;
        end
        OVER: begin
          collision <= 1'b1;
          game_over <= 1'b1;
          lives     <= 4'd0;
        end
        default: state <= PLAY;
      endcase
    end
  end

endmodule

// File: tb/tb_collision_ctrl.sv
// Scoreboard bench for collision_ctrl: a tick-level reference model queues expected outputs,
// a monitor compares them one tick after each stimulus.
module tb_collision_ctrl;

  localparam int CAR_W    = 80;
  localparam int CAR_H    = 121;
  localparam int SCREEN_H = 480;
  localparam int LIVES    = 3;
  localparam int FREEZE   = 4;
  localparam int GRACE    = 3;
`ifdef INVULN_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic        logic_clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  player_x = '0, player_y = '0, enemy_x = '0, enemy_y = '0;
  logic        collision, respawn, game_over, invuln;
  logic [3:0]  lives;
  logic [15:0] score;

  collision_ctrl #(
    .CAR_W(CAR_W), .CAR_H(CAR_H), .SCREEN_H(SCREEN_H), .LIVES(LIVES), .FREEZE_TICKS(FREEZE)
`ifdef INVULN_EN
    , .GRACE_TICKS(GRACE)
`endif
  ) dut (
    .logic_clk(logic_clk), .reset(reset),
    .player_x(player_x), .player_y(player_y), .enemy_x(enemy_x), .enemy_y(enemy_y),
    .collision(collision), .respawn(respawn), .lives(lives), .score(score),
    .game_over(game_over), .invuln(invuln)
  );

  always #5 logic_clk = ~logic_clk;

  typedef struct packed {
    logic        collision;
    logic        respawn;
    logic [3:0]  lives;
    logic [15:0] score;
    logic        game_over;
    logic        invuln;
  } exp_t;

  exp_t expQ[$];
  int compared = 0;
  int mismatched = 0;

  // Reference model: counts of lives/score, remaining frozen ticks and grace ticks
  int mLives, mScore, mHitLeft, mGrace;
  bit mOver, mInResp, mPass, mCol, mResp;

  function automatic exp_t modelStep(input bit rst, input int px, input int py,
                                     input int ex, input int ey);
    exp_t e;
    bit ov, passed, newPass, shielded;
    if (rst) begin
      mLives = LIVES; mScore = 0; mHitLeft = 0; mGrace = 0;
      mOver = 0; mInResp = 0; mPass = 0; mCol = 0; mResp = 0;
    end else begin
      ov = (ex < px + CAR_W) && (px < ex + CAR_W) && (ey < py + CAR_H) && (py < ey + CAR_H);
      passed = (ey >= SCREEN_H);
      newPass = passed ? mPass : 1'b0;
      mResp = 0;
      if (mOver) begin
      end else if (mHitLeft > 0) begin
        if (mLives == 0) begin
          mOver = 1; mHitLeft = 0;
        end else begin
          mHitLeft--;
          if (mHitLeft == 0) begin mCol = 0; mResp = 1; mInResp = 1; end
        end
      end else if (mInResp) begin
        mInResp = 0; newPass = 1;
        if (INV) mGrace = GRACE;
      end else begin
        shielded = (mGrace > 0);
        if (mGrace > 0) mGrace--;
        if (ov && !shielded) begin
          mLives--; mCol = 1; mHitLeft = FREEZE + 1;
        end else if (passed && !mPass) begin
          mScore = (mScore + 1) % 65536; newPass = 1; mResp = 1;
        end
      end
      mPass = newPass;
    end
    e.collision = mCol || mOver;
    e.respawn   = mResp;
    e.lives     = mOver ? 4'd0 : 4'(mLives);
    e.score     = 16'(mScore);
    e.game_over = mOver;
    e.invuln    = (mGrace > 0);
    return e;
  endfunction

  task automatic applyStimulus(input bit rst, input int px, input int py,
                               input int ex, input int ey, input int ticks);
    for (int t = 0; t < ticks; t++) begin
      @(negedge logic_clk);
      reset = rst;
      player_x = 10'(px); player_y = 10'(py);
      enemy_x = 10'(ex); enemy_y = 10'(ey);
      expQ.push_back(modelStep(rst, px, py, ex, ey));
    end
  endtask

  task automatic cmp(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("collision", int'(collision), int'(e.collision));
    cmp("respawn",   int'(respawn),   int'(e.respawn));
    cmp("lives",     int'(lives),     int'(e.lives));
    cmp("score",     int'(score),     int'(e.score));
    cmp("game_over", int'(game_over), int'(e.game_over));
    cmp("invuln",    int'(invuln),    int'(e.invuln));
  endtask

  // Monitor: outputs are presented every tick, checked 1 time unit after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge logic_clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    int px, py, ex, ey, hold;
    // Reset then idle, edge touch, one-pixel overlap and the full freeze
    applyStimulus(1, 280, 350, 100, 0, 2);
    applyStimulus(0, 280, 350, 100, 0, 10);
    applyStimulus(0, 280, 350, 200, 350, 3);
    applyStimulus(0, 280, 350, 201, 350, 1);
    applyStimulus(0, 280, 350, 100, 0, 9);
    // Pass sweep, hold past the bottom, then a second pass
    for (int y = 470; y <= 485; y++) applyStimulus(0, 280, 350, 100, y, 1);
    applyStimulus(0, 280, 350, 100, 485, 5);
    applyStimulus(0, 280, 350, 100, 0, 2);
    applyStimulus(0, 280, 350, 100, 480, 3);
    applyStimulus(0, 280, 350, 100, 0, 2);
    // Overlap held continuously: re-hits (or grace), eventually game over and a long OVER hold
    applyStimulus(0, 280, 350, 280, 350, 60);
    applyStimulus(1, 280, 350, 280, 350, 1);
    applyStimulus(0, 280, 350, 100, 0, 3);
    // Randomized play with occasional reset
    for (int i = 0; i < 400; i++) begin
      px = $urandom_range(0, 560);
      py = $urandom_range(0, 359);
      case ($urandom_range(0, 3))
        0: begin ex = $urandom_range(0, 639); ey = $urandom_range(0, 520); end
        1: begin
             ex = px + $urandom_range(0, 180) - 90;
             ey = py + $urandom_range(0, 260) - 130;
           end
        2: begin ex = $urandom_range(0, 639); ey = $urandom_range(470, 500); end
        default: begin
             ex = px + ($urandom_range(0, 1) ? CAR_W : -CAR_W);
             ey = py;
           end
      endcase
      if (ex < 0) ex = 0;
      if (ex > 1023) ex = 1023;
      if (ey < 0) ey = 0;
      if (ey > 1023) ey = 1023;
      hold = $urandom_range(1, 6);
      applyStimulus(($urandom_range(0, 99) == 0), px, py, ex, ey, hold);
    end
    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && expQ.size() > 0; k++) @(posedge logic_clk);
    #2;
    if (expQ.size() > 0) begin
      mismatched++;
      $display("[TB] FAIL drain: got %0d pending, required 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
